spi_reg_bridge: RTL and testbench
=================================

// Module: spi_reg_bridge
// PURPOSE
//  SPI slave front end (mode 0, CPOL=0/CPHA=0) that turns 32-bit SPI frames into
//  single-cycle accesses on the parallel register interface of the spi_reg block.
//  It sits between the SPI pads and the register file, driving addr/wdata/wr
//  into spi_reg and returning registered read data on MISO.
//  SCLK, CS_N and MOSI are oversampled in the clk domain. No SCLK clocking is used.
// PARAMETERS
//  SYNC_STAGES  2   flops per synchroniser on i_sclk/i_cs_n/i_mosi (>=2)
//  RD_LAT       1   clk cycles from o_addr stable (o_wr=0) to valid i_rdata
//  ADDR_W       16  width of o_addr; upper bits above the 15-bit frame field are zero
// PORTS
//  clk         in   1       system clock; all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  i_sclk      in   1       SPI clock from master, asynchronous
//  i_cs_n      in   1       SPI chip select, active low, asynchronous
//  i_mosi      in   1       SPI master-out data, asynchronous
//  o_miso      out  1       SPI slave-out data
//  o_miso_oe   out  1       MISO output enable; high only while CS is low (synced)
//  o_addr      out  ADDR_W  register address to spi_reg
//  o_wdata     out  16      register write data to spi_reg
//  o_wr        out  1       write strike to spi_reg, one clk wide
//  i_rdata     in   16      registered read data from spi_reg
//  o_frame_err out  1       one-clk pulse: CS released before 32 bits were received
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE. Shift regs and counters are 0.
//  Frame, MSB first: [31]=W (1 write, 0 read), [30:16]=addr[14:0], [15:0]=data.
//  Edge detect: rise/fall pulses come from synced SCLK (sync + 1 history flop).
//    The MOSI sample comes from the same synced stage.
//  FSM:
//   IDLE   : synced CS_N falls -> CMD. Clear bit count.
//   CMD    : shift MOSI on each SCLK rise. After the 16th rise, latch W and addr.
//            Drive o_addr={0,addr} and o_wr=0.
//            W=1 -> DATA. W=0 -> FETCH.
//   FETCH  : wait RD_LAT+1 clk, then load i_rdata into TX shift reg -> DATA.
//            o_addr is held for the whole frame.
//   DATA   : shift MOSI on rises 17..32.
//            On read, MISO=tx[15]. tx shifts on each SCLK fall after rise 17.
//            The fall following rise 16 does not shift.
//            After rise 32: W=1 -> COMMIT. W=0 -> DONE.
//   COMMIT : o_wdata<=rx[15:0]; o_wr=1 for exactly one clk -> DONE.
//   DONE   : ignore SCLK. CS_N rise -> IDLE.
//  o_wdata/o_addr hold their values until the next frame updates them.
//  During a write frame o_miso=0.
//  Timing requirement on master: SCLK high and low times each >= SYNC_STAGES+RD_LAT+3 clk.
//    This guarantees FETCH completes before fall 16.
//  Boundaries:
//   - CS_N rises in any state except IDLE/DONE -> o_frame_err pulse, no o_wr -> IDLE.
//   - CS_N rise and rise 32 detected in the same clk: the bit counts; frame completes.
//     Write still commits in the next clk.
//   - Clocks beyond 32 while CS low: ignored (DONE).
//   - Back-to-back frames: DONE->IDLE->CMD needs >=1 clk of CS_N high (synced).
//   - rst mid-frame: immediate return to IDLE and all outputs 0.
//     After reset the frame in flight is discarded. The next CS_N fall is needed to restart.
//   - o_wr never asserts on a read frame or an aborted frame.
// STRUCTURE
//  Shared pkg spi_bridge_pkg: state enum {IDLE,CMD,FETCH,DATA,COMMIT,DONE},
//  FRAME_BITS=32, HDR_BITS=16, bit position constant for W.
//  One sub-module spi_sync_edge: N-stage synchroniser + rise/fall pulse outputs.
//  It is instantiated for SCLK and CS_N; MOSI uses its sync path only.
//  Top holds FSM, 6-bit bit counter, 32-bit RX shift reg, 16-bit TX shift reg.
// TESTING (SCLK half period 8 clk unless noted)
//  Write frame 0x8000_0123 -> o_addr=0x0000, o_wdata=0x0123, single o_wr pulse after CS edge 32.
//  Read frame 0x0002_0000 with i_rdata model of spi_reg (park=1) -> MISO bits 16..31 = 0x0001.
//    o_wr stays 0.
//  CS_N released after 10 bits of 0x8004_0001 -> o_frame_err one pulse, o_wr never 1.
//    The following valid write to 0x0004 succeeds.
//  Two frames back-to-back, CS high 3 clk: write 0x8000_ABCD, then read 0x0000_0000.
//    MISO returns 0xABCD.
//  rst asserted at bit 20 of a write -> no o_wr; all outputs 0 next clk.
//    A fresh frame after reset works.
//  SCLK half period at minimum (SYNC_STAGES+RD_LAT+3=6 clk) read of addr 0x0000 after reset.
//    MISO returns 0x0100 with no bit slip.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// Shared types and frame constants for the SPI-to-register bridge.
package spi_bridge_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned HDR_BITS   = 16;
  localparam int unsigned DATA_BITS  = 16;
  localparam int unsigned FADDR_W    = 15;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned W_BIT      = 31;
  // Where the W bit sits in rx at the moment the 16th bit arrives (15 bits held).
  localparam int unsigned HDR_W_POS  = W_BIT - HDR_BITS - 1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    FETCH,
    DATA,
    COMMIT,
    DONE
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input plus rise/fall pulses.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   d         : asynchronous input
//   q         : synchronised level
//   rise_c    : one-clk pulse when q goes 0->1 (combinational)
//   fall_c    : one-clk pulse when q goes 1->0 (combinational)
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_c = q & ~hist_q;
  assign fall_c = ~q & hist_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 32-bit frames into single-cycle accesses on a
// parallel register interface. SPI pins are oversampled in the clk domain.
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   i_sclk/i_cs_n/i_mosi: asynchronous SPI inputs from the master
//   o_miso, o_miso_oe   : SPI slave data out and its output enable
//   o_addr, o_wdata     : register address / write data (held between frames)
//   o_wr                : one-clk write strobe
//   i_rdata             : registered read data, RD_LAT clk after o_addr
//   o_frame_err         : one-clk pulse when CS is released mid-frame
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_sclk,
  input  logic                 i_cs_n,
  input  logic                 i_mosi,
  output logic                 o_miso,
  output logic                 o_miso_oe,
  output logic [ADDR_W-1:0]    o_addr,
  output logic [DATA_BITS-1:0] o_wdata,
  output logic                 o_wr,
  input  logic [DATA_BITS-1:0] i_rdata,
  output logic                 o_frame_err
);

  localparam int unsigned WAIT_W = $clog2(RD_LAT + 2);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [FRAME_BITS-1:0]  rx_q;
  logic [DATA_BITS-1:0]   tx_q;
  logic                   w_q;
  logic [WAIT_W-1:0]      wait_q;

  logic sclk_q, sclk_rise_c, sclk_fall_c;
  logic cs_q, cs_rise_c, cs_fall_c;
  logic mosi_q, mosi_rise_c, mosi_fall_c;

  logic start_c, abort_c, rx_shift_c, hdr_done_c, tx_load_c, tx_shift_c;
  logic frame_end_c;
  logic unused_c;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(i_sclk),
    .q(sclk_q), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .d(i_cs_n),
    .q(cs_q), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(i_mosi),
    .q(mosi_q), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
  );

  assign unused_c = ^{sclk_q, mosi_rise_c, mosi_fall_c, rx_q[FRAME_BITS-1]};

  assign frame_end_c = sclk_rise_c && (bit_cnt_q == CNT_W'(FRAME_BITS - 1));

  // Next-state and per-cycle action decode.
  always_comb begin
    state_d    = state_q;
    start_c    = 1'b0;
    abort_c    = 1'b0;
    rx_shift_c = 1'b0;
    hdr_done_c = 1'b0;
    tx_load_c  = 1'b0;
    tx_shift_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall_c) begin
          start_c = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        if (cs_rise_c) begin
          abort_c = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise_c) begin
          rx_shift_c = 1'b1;
          if (bit_cnt_q == CNT_W'(HDR_BITS - 1)) begin
            hdr_done_c = 1'b1;
            state_d    = rx_q[HDR_W_POS] ? DATA : FETCH;
          end
        end
      end
      FETCH: begin
        if (cs_rise_c) begin
          abort_c = 1'b1;
          state_d = IDLE;
        end else if (wait_q == WAIT_W'(RD_LAT)) begin
          tx_load_c = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        // A CS release coinciding with the last rise still completes the frame.
        if (cs_rise_c && !frame_end_c) begin
          abort_c = 1'b1;
          state_d = IDLE;
        end else begin
          if (sclk_rise_c) begin
            rx_shift_c = 1'b1;
            if (frame_end_c) state_d = w_q ? COMMIT : DONE;
          end
          // The fall right after the last header bit leaves tx untouched.
          if (sclk_fall_c && (bit_cnt_q >= CNT_W'(HDR_BITS + 1))) tx_shift_c = 1'b1;
        end
      end
      COMMIT: state_d = DONE;
      // Level check so a CS release seen during COMMIT is not missed.
      DONE:   if (cs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      w_q         <= 1'b0;
      wait_q      <= '0;
      o_miso      <= 1'b0;
      o_miso_oe   <= 1'b0;
      o_addr      <= '0;
      o_wdata     <= '0;
      o_wr        <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start_c) begin
        bit_cnt_q <= '0;
        rx_q      <= '0;
      end else if (rx_shift_c) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        rx_q      <= {rx_q[FRAME_BITS-2:0], mosi_q};
      end

      if (hdr_done_c) begin
        w_q    <= rx_q[HDR_W_POS];
        o_addr <= ADDR_W'({rx_q[HDR_W_POS-1:0], mosi_q});
      end

      wait_q <= (state_q == FETCH) ? wait_q + 1'b1 : '0;

      if (tx_load_c)       tx_q <= i_rdata;
      else if (tx_shift_c) tx_q <= {tx_q[DATA_BITS-2:0], 1'b0};

      if (state_q == COMMIT) o_wdata <= rx_q[DATA_BITS-1:0];
      o_wr        <= (state_q == COMMIT);
      o_frame_err <= abort_c;
      o_miso      <= (state_q == DATA) && !w_q && tx_q[DATA_BITS-1];
      o_miso_oe   <= (state_q != IDLE) && !cs_q;
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge with a small spi_reg register model.
module tb_spi_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, cs_n, mosi;
  logic        miso, miso_oe, wr, frame_err;
  logic [15:0] addr, wdata, rdata;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  logic [15:0] last_wr_addr, last_wr_data;
  logic [31:0] miso_bits;
  logic [15:0] regs [0:7];

  spi_reg_bridge #(.SYNC_STAGES(2), .RD_LAT(1), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe), .o_addr(addr), .o_wdata(wdata),
    .o_wr(wr), .i_rdata(rdata), .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register file model: reset values 0x0100 at 0 and 0x0001 at 2, 1-clk read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
      regs[0] <= 16'h0100;
      regs[2] <= 16'h0001;
      rdata   <= 16'h0000;
    end else begin
      if (wr && addr < 16'd8) regs[addr[2:0]] <= wdata;
      rdata <= (addr < 16'd8) ? regs[addr[2:0]] : 16'h0000;
    end
  end

  // Pulse monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wr_cnt++;
      last_wr_addr = addr;
      last_wr_data = wdata;
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clock out bits [first .. first+n-1] of a frame, MSB first; capture MISO on rises.
  task automatic spi_bits(input logic [31:0] frame, input int first, input int n, input int half);
    for (int i = first; i < first + n; i++) begin
      mosi = frame[31-i];
      wait_clk(half);
      sclk = 1'b1;
      miso_bits[31-i] = miso;
      wait_clk(half);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] frame, input int half, input int gap);
    cs_n = 1'b0;
    wait_clk(half);
    spi_bits(frame, 0, 32, half);
    wait_clk(half);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(gap);
  endtask

  task automatic test_reset();
    logic [35:0] outs;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    wait_clk(3);
    outs = {miso, miso_oe, addr, wdata, wr, frame_err};
    checks++;
    if (outs !== 36'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", outs, 36'h0);
    end
    rst = 1'b0;
    wait_clk(4);
    outs = {miso, miso_oe, addr, wdata, wr, frame_err};
    checks++;
    if (outs !== 36'h0) begin
      errors++; $display("FAIL idle_outputs: got %h expected %h", outs, 36'h0);
    end
  endtask

  task automatic test_write();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(32'h8000_0123, 8, 6);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL write_wr_pulses: got %0d expected 1", wr_cnt - w0); end
    checks++; if (last_wr_addr !== 16'h0000) begin errors++; $display("FAIL write_strobe_addr: got %h expected 0000", last_wr_addr); end
    checks++; if (last_wr_data !== 16'h0123) begin errors++; $display("FAIL write_strobe_data: got %h expected 0123", last_wr_data); end
    checks++; if (wdata !== 16'h0123) begin errors++; $display("FAIL write_wdata_hold: got %h expected 0123", wdata); end
    checks++; if (miso_bits !== 32'h0) begin errors++; $display("FAIL write_miso_zero: got %h expected 00000000", miso_bits); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL write_no_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL write_oe_after_cs: got %b expected 0", miso_oe); end
  endtask

  task automatic test_read();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(32'h0002_0000, 8, 6);
    checks++; if (miso_bits[15:0] !== 16'h0001) begin errors++; $display("FAIL read_data: got %h expected 0001", miso_bits[15:0]); end
    checks++; if (miso_bits[31:16] !== 16'h0000) begin errors++; $display("FAIL read_hdr_miso: got %h expected 0000", miso_bits[31:16]); end
    checks++; if (addr !== 16'h0002) begin errors++; $display("FAIL read_addr: got %h expected 0002", addr); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL read_no_wr: got %0d expected 0", wr_cnt - w0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL read_no_err: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_abort();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    cs_n = 1'b0;
    wait_clk(8);
    spi_bits(32'h8004_0001, 0, 10, 8);
    wait_clk(8);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(6);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL abort_err_pulse: got %0d expected 1", err_cnt - e0); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL abort_no_wr: got %0d expected 0", wr_cnt - w0); end
    spi_frame(32'h8004_0001, 8, 6);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL abort_retry_wr: got %0d expected 1", wr_cnt - w0); end
    checks++; if (addr !== 16'h0004) begin errors++; $display("FAIL abort_retry_addr: got %h expected 0004", addr); end
    checks++; if (wdata !== 16'h0001) begin errors++; $display("FAIL abort_retry_wdata: got %h expected 0001", wdata); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL abort_retry_err: got %0d expected 1", err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(32'h8000_ABCD, 8, 3);
    spi_frame(32'h0000_0000, 8, 6);
    checks++; if (miso_bits[15:0] !== 16'hABCD) begin errors++; $display("FAIL b2b_read_data: got %h expected abcd", miso_bits[15:0]); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL b2b_wr_pulses: got %0d expected 1", wr_cnt - w0); end
    checks++; if (last_wr_data !== 16'hABCD) begin errors++; $display("FAIL b2b_wr_data: got %h expected abcd", last_wr_data); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_no_err: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid_frame();
    int w0, e0;
    logic [35:0] outs;
    w0 = wr_cnt; e0 = err_cnt;
    cs_n = 1'b0;
    wait_clk(8);
    spi_bits(32'h8006_1234, 0, 20, 8);
    checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL mid_oe_active: got %b expected 1", miso_oe); end
    checks++; if (addr !== 16'h0006) begin errors++; $display("FAIL mid_addr_latched: got %h expected 0006", addr); end
    rst = 1'b1;
    wait_clk(1);
    outs = {miso, miso_oe, addr, wdata, wr, frame_err};
    checks++; if (outs !== 36'h0) begin errors++; $display("FAIL mid_rst_outputs: got %h expected %h", outs, 36'h0); end
    rst = 1'b0;
    spi_bits(32'h8006_1234, 20, 12, 8);
    wait_clk(8);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(6);
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL mid_no_wr: got %0d expected 0", wr_cnt - w0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL mid_no_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL mid_addr_cleared: got %h expected 0000", addr); end
    spi_frame(32'h8003_5A5A, 8, 6);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL mid_fresh_wr: got %0d expected 1", wr_cnt - w0); end
    checks++; if (addr !== 16'h0003) begin errors++; $display("FAIL mid_fresh_addr: got %h expected 0003", addr); end
    checks++; if (wdata !== 16'h5A5A) begin errors++; $display("FAIL mid_fresh_wdata: got %h expected 5a5a", wdata); end
  endtask

  task automatic test_min_period();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(32'h0000_0000, 6, 6);
    checks++; if (miso_bits[15:0] !== 16'h0100) begin errors++; $display("FAIL minper_read_data: got %h expected 0100", miso_bits[15:0]); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL minper_no_wr: got %0d expected 0", wr_cnt - w0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL minper_no_err: got %0d expected 0", err_cnt - e0); end
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    test_min_period();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
